// File: rtl/soc_bus_pkg.sv
// Shared bus types for the memory arbiter: FSM states, master index and
// the round-robin pick helper.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_idx_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // On a tie the master that did not win last time gets the grant.
  function automatic mst_idx_t rr_pick(input logic v0, input logic v1, input mst_idx_t last);
    if (v0 && v1) begin
      return (last == MST_CPU) ? MST_DMA : MST_CPU;
    end else if (v1) begin
      return MST_DMA;
    end
    return MST_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Two-master / one-slave memory bus bundle. The arbiter uses the slave
// modport; whatever drives the masters and the memory uses master.
interface mem_arbiter_if;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        err, err_clr;

  modport slave (
    input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_wstrb, m1_wstrb, s_ready, s_rdata, err_clr,
    output m0_ready, m1_ready, m0_rdata, m1_rdata,
           s_valid, s_addr, s_wdata, s_wstrb, err
  );

  modport master (
    output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_wstrb, m1_wstrb, s_ready, s_rdata, err_clr,
    input  m0_ready, m1_ready, m0_rdata, m1_rdata,
           s_valid, s_addr, s_wdata, s_wstrb, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU and a DMA master access to one memory
// port, with a per-transfer wait timeout and a sticky error flag.
module mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  arb_state_t  state;
  mst_idx_t    grant;
  mst_idx_t    last_grant;
  mst_idx_t    pick;
  logic [15:0] wait_cnt;
  logic        busy;
  logic        xfer_end;
  logic        tmo_hit;
  logic [31:0] xfer_rdata;

  assign pick       = rr_pick(bus.m0_valid, bus.m1_valid, last_grant);
  assign busy       = (state == ST_BUSY) && !reset;
  assign xfer_end   = busy && (bus.s_ready || (wait_cnt == TMO));
  // s_ready wins over a coinciding timeout
  assign tmo_hit    = busy && !bus.s_ready && (wait_cnt == TMO);
  assign xfer_rdata = bus.s_ready ? bus.s_rdata : ERR_RDATA;

  assign bus.m0_ready = xfer_end && (grant == MST_CPU);
  assign bus.m1_ready = xfer_end && (grant == MST_DMA);
  assign bus.m0_rdata = bus.m0_ready ? xfer_rdata : 32'h0;
  assign bus.m1_rdata = bus.m1_ready ? xfer_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= MST_CPU;
      last_grant  <= MST_DMA;
      wait_cnt    <= 16'd0;
      bus.s_valid <= 1'b0;
      bus.s_addr  <= 32'h0;
      bus.s_wdata <= 32'h0;
      bus.s_wstrb <= 4'h0;
      bus.err     <= 1'b0;
    end else begin
      if (tmo_hit) begin
        bus.err <= 1'b1;
      end else if (bus.err_clr) begin
        bus.err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.m0_valid || bus.m1_valid) begin
            grant       <= pick;
            last_grant  <= pick;
            bus.s_addr  <= (pick == MST_DMA) ? bus.m1_addr  : bus.m0_addr;
            bus.s_wdata <= (pick == MST_DMA) ? bus.m1_wdata : bus.m0_wdata;
            bus.s_wstrb <= (pick == MST_DMA) ? bus.m1_wstrb : bus.m0_wstrb;
            bus.s_valid <= 1'b1;
            wait_cnt    <= 16'd0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.s_ready || (wait_cnt == TMO)) begin
            bus.s_valid <= 1'b0;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          bus.s_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver issues rounds of master
// requests, a slave responder follows a per-transfer plan, a monitor checks.
module tb_mem_arbiter;

  localparam int TMO = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    bit          mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          busy_len;
    bit          timeout;
  } exp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  logic clk;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(ERR_WORD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  plan_t plan_q[$];
  int   ready_cnt[2];
  bit   model_last = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic exp_t mk_exp(input bit m, input req_t r);
    exp_t e;
    e.mst      = m;
    e.addr     = r.addr;
    e.wdata    = r.wdata;
    e.wstrb    = r.wstrb;
    e.timeout  = (r.delay > TMO);
    e.rdata    = e.timeout ? ERR_WORD : r.rdata;
    e.busy_len = e.timeout ? TMO + 1 : r.delay + 1;
    return e;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                                  input int d, input logic [31:0] rd);
    req_t r;
    r.addr = a; r.wdata = w; r.wstrb = s; r.delay = d; r.rdata = rd;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk_req({$urandom_range(0, 255), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, TMO + 3), $urandom);
  endfunction

  function automatic void queue_xfer(input bit m, input req_t r);
    plan_t p;
    exp_q.push_back(mk_exp(m, r));
    p.delay = r.delay;
    p.rdata = r.rdata;
    plan_q.push_back(p);
  endfunction

  task automatic drive_master(input bit m, input req_t r);
    if (m) begin
      bus.m1_valid = 1'b1; bus.m1_addr = r.addr; bus.m1_wdata = r.wdata; bus.m1_wstrb = r.wstrb;
    end else begin
      bus.m0_valid = 1'b1; bus.m0_addr = r.addr; bus.m0_wdata = r.wdata; bus.m0_wstrb = r.wstrb;
    end
  endtask

  // Service order follows the round-robin rule: a tie goes to whoever was not served last.
  task automatic do_round(input bit u0, input bit u1, input req_t r0, input req_t r1, input bit drop);
    bit   first;
    bit [1:0] pending;
    int   base0, base1;
    first = (u0 && u1) ? ~model_last : u1;
    queue_xfer(first, first ? r1 : r0);
    if (u0 && u1) begin
      queue_xfer(~first, first ? r0 : r1);
      model_last = ~first;
    end else begin
      model_last = first;
    end
    @(negedge clk);
    base0 = ready_cnt[0];
    base1 = ready_cnt[1];
    if (u0) drive_master(1'b0, r0);
    if (u1) drive_master(1'b1, r1);
    pending = {u1, u0};
    for (int c = 0; c < 300 && pending != 2'b00; c++) begin
      @(negedge clk);
      if (drop && c == 0) begin
        bus.m0_valid = 1'b0;
        bus.m1_valid = 1'b0;
      end
      if (pending[0] && ready_cnt[0] != base0) begin pending[0] = 1'b0; bus.m0_valid = 1'b0; end
      if (pending[1] && ready_cnt[1] != base1) begin pending[1] = 1'b0; bus.m1_valid = 1'b0; end
    end
    n_tests++;
    if (pending != 2'b00) begin
      n_fail++;
      $display("FAIL round_done: pending masters %b expected 00", pending);
      bus.m0_valid = 1'b0;
      bus.m1_valid = 1'b0;
      repeat (TMO + 4) @(negedge clk);
      exp_q.delete();
      plan_q.delete();
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Slave responder: waits plan.delay cycles with s_ready low, then completes.
  initial begin
    plan_t p;
    bit    active;
    int    cnt;
    active = 1'b0;
    cnt = 0;
    p.delay = 0;
    p.rdata = 32'h0;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        bus.s_ready = 1'b0;
        plan_q.delete();
      end else if (!bus.s_valid) begin
        active = 1'b0;
        bus.s_ready = 1'b0;
        bus.s_rdata = $urandom;
      end else begin
        if (!active) begin
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else begin p.delay = 0; p.rdata = 32'h0; end
          active = 1'b1;
          cnt = 0;
        end
        if (cnt == p.delay) begin
          bus.s_ready = 1'b1;
          bus.s_rdata = p.rdata;
        end else begin
          bus.s_ready = 1'b0;
          bus.s_rdata = $urandom;
          cnt++;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   in_xfer, done_chk, rst_seen, err_exp, mst;
    int   busy_cnt;
    in_xfer = 0; done_chk = 0; rst_seen = 0; err_exp = 0; busy_cnt = 0;
    ready_cnt[0] = 0;
    ready_cnt[1] = 0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        chk("reset_no_ready", {30'h0, bus.m1_ready, bus.m0_ready}, 32'h0);
        rst_seen = 1; in_xfer = 0; done_chk = 0; err_exp = 0;
        exp_q.delete();
      end else begin
        if (rst_seen) begin
          chk("reset_s_valid", {31'h0, bus.s_valid}, 32'h0);
          chk("reset_s_fields", bus.s_addr | bus.s_wdata | {28'h0, bus.s_wstrb}, 32'h0);
          rst_seen = 0;
        end
        chk("err_flag", {31'h0, bus.err}, {31'h0, err_exp});
        if (done_chk) begin
          chk("done_quiet", {29'h0, bus.s_valid, bus.m1_ready, bus.m0_ready}, 32'h0);
          done_chk = 0;
        end
        if (!bus.m0_ready) chk("m0_rdata_idle", bus.m0_rdata, 32'h0);
        if (!bus.m1_ready) chk("m1_rdata_idle", bus.m1_rdata, 32'h0);
        if (bus.s_valid) begin
          if (!in_xfer) begin in_xfer = 1; busy_cnt = 0; end
          busy_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL s_valid_unexpected: got s_valid=1 expected no transfer");
          end else begin
            chk("s_addr", bus.s_addr, exp_q[0].addr);
            chk("s_wdata", bus.s_wdata, exp_q[0].wdata);
            chk("s_wstrb", {28'h0, bus.s_wstrb}, {28'h0, exp_q[0].wstrb});
          end
        end else begin
          in_xfer = 0;
        end
        if (bus.m0_ready || bus.m1_ready) begin
          chk("single_ready", {31'h0, bus.m0_ready & bus.m1_ready}, 32'h0);
          mst = bus.m1_ready;
          ready_cnt[mst]++;
          done_chk = 1;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ready_unexpected: got ready from m%0d expected none", mst);
          end else begin
            e = exp_q.pop_front();
            chk("grant_order", {31'h0, mst}, {31'h0, e.mst});
            chk("rdata", mst ? bus.m1_rdata : bus.m0_rdata, e.rdata);
            chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_len));
            if (e.timeout) err_exp = 1;
            else if (bus.err_clr) err_exp = 0;
          end
        end else if (bus.err_clr) begin
          err_exp = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    req_t ra, rb, rz;
    int   sel;
    reset = 1'b1;
    bus.m0_valid = 0; bus.m1_valid = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
    bus.m0_wstrb = 0; bus.m1_wstrb = 0; bus.err_clr = 0;
    rz = mk_req(32'h0, 32'h0, 4'h0, 0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single read, 3 wait cycles
    do_round(1, 0, mk_req(32'h0000_0100, 32'h0, 4'h0, 3, 32'h1234_5678), rz, 0);
    // two ties in a row: m0 first both times
    do_round(1, 1, mk_req(32'h10, 32'h0, 4'h0, 1, 32'hAAAA_0001),
                   mk_req(32'h20, 32'h0, 4'h0, 2, 32'hBBBB_0002), 0);
    do_round(1, 1, mk_req(32'h14, 32'h0, 4'h0, 0, 32'hAAAA_0003),
                   mk_req(32'h24, 32'h0, 4'h0, 0, 32'hBBBB_0004), 0);
    // DMA write with partial strobes
    do_round(0, 1, rz, mk_req(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 4, 32'h0), 0);
    // slave never ready -> timeout, then clear
    do_round(1, 0, mk_req(32'h80, 32'h0, 4'h0, 1000, 32'h0), rz, 0);
    pulse_err_clr();
    // ready exactly at the timeout count
    do_round(1, 0, mk_req(32'h84, 32'h0, 4'h0, TMO, 32'h5555_AAAA), rz, 0);
    // master drops valid during BUSY
    do_round(0, 1, rz, mk_req(32'h90, 32'h0, 4'h0, 2, 32'h0BAD_F00D), 1);

    // reset in the second BUSY cycle
    ra = mk_req(32'hC0, 32'h0, 4'h0, 20, 32'h0);
    queue_xfer(1'b0, ra);
    @(negedge clk);
    drive_master(1'b0, ra);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.m0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    do_round(1, 1, mk_req(32'hD0, 32'h0, 4'h0, 1, 32'hC0DE_0000),
                   mk_req(32'hD4, 32'h0, 4'h0, 1, 32'hC0DE_0001), 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      ra = rnd_req();
      rb = rnd_req();
      do_round(sel[0], sel[1], ra, rb, (sel != 3) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) pulse_err_clr();
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum slave wait in cycles before forced completion (legal range 1..65535).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, SHALL be the read data returned on a timed-out transfer.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_valid, m1_valid  in  1 each  master 0 (CPU) and master 1 (DMA) request.
REQ-006 m0_ready, m1_ready  out  1 each  transfer-complete strobe to each master.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  in  32 each  write data.
REQ-009 m0_wstrb, m1_wstrb  in  4 each  byte write strobes; 0 means read.
REQ-010 m0_rdata, m1_rdata  out  32 each  read data.
REQ-011 s_valid  out  1  request to the shared memory bus.
REQ-012 s_ready, s_rdata  in  1, 32  slave completion and read data.
REQ-013 s_addr, s_wdata, s_wstrb  out  32, 32, 4  registered copy of the granted request.
REQ-014 err  out  1  sticky timeout flag.
REQ-015 err_clr  in  1  clears err.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE with exactly one mi_valid high, the block SHALL grant that master, latch its addr/wdata/wstrb, and enter BUSY on the next edge.
REQ-018 In IDLE with both valid high, the block SHALL grant the master that was not granted last (round-robin); after reset, master 0 SHALL win the first tie.
REQ-019 In BUSY, s_valid SHALL be 1 and s_addr/s_wdata/s_wstrb SHALL hold the latched values unchanged.
REQ-020 In BUSY with s_ready=1, the granted mi_ready SHALL be 1 in that same cycle and mi_rdata SHALL equal s_rdata (combinational pass-through); the FSM SHALL then enter DONE.
REQ-021 The non-granted master's ready SHALL be 0 and its rdata SHALL be 0 at all times.
REQ-022 DONE SHALL last exactly one cycle with s_valid=0 and both readies 0, then return to IDLE, so that the master can drop valid before re-arbitration.
REQ-023 Minimum transfer latency SHALL be 2 cycles from mi_valid high in IDLE to mi_ready; back-to-back occupancy SHALL be 1 cycle of grant, N cycles of BUSY, and 1 cycle of DONE.
REQ-024 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle with s_ready=0.
REQ-025 When the counter equals TIMEOUT with s_ready=0, the block SHALL complete the transfer: mi_ready=1, mi_rdata=ERR_RDATA, and s_valid=0 from the next cycle. It SHALL set err and enter DONE.
REQ-026 If s_ready and the timeout coincide, s_ready SHALL take precedence: normal data is returned and err is not set.
REQ-027 If the granted master drops valid during BUSY, the transfer SHALL still complete on the slave side, with no abort.
REQ-028 err_clr SHALL clear err; a simultaneous timeout SHALL take precedence, leaving err=1.

Reset
REQ-029 On reset, the FSM SHALL be in IDLE, with s_valid=0, s_addr/s_wdata=0, s_wstrb=0, m0_ready=m1_ready=0, err=0, the counter at 0, and last-grant=master 1.
REQ-030 A reset asserted mid-BUSY SHALL drop s_valid on the next edge and issue no ready to either master.

Structure
REQ-031 State encoding, the master-index type, and the default ERR_RDATA SHALL live in a shared package, soc_bus_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the round-robin pointer is one register bit.

Verification
REQ-033 m0 reads 0x0000_0100 alone and the slave gives ready after 3 wait cycles with rdata 0x1234_5678 -> m0_ready pulses once, m0_rdata=0x1234_5678, m1_ready stays 0.
REQ-034 m0 and m1 raise valid in the same cycle right after reset -> m0 is served first, then m1; on the next tie, m0 is served first again, because m1 was last granted.
REQ-035 m1 writes wdata 0xA5A5_A5A5 with wstrb 4'b0011 to 0x0000_0040 -> s_wstrb=4'b0011 and the fields stay stable on the slave side for every BUSY cycle.
REQ-036 With TIMEOUT=8 and the slave never ready -> m0_ready occurs exactly 9 cycles after BUSY entry, m0_rdata=0xDEAD_BEEF, err=1; err_clr then gives err=0.
REQ-037 The slave asserts ready in the same cycle the count reaches TIMEOUT -> normal rdata is returned and err stays 0.
REQ-038 Reset is asserted in the 2nd BUSY cycle -> s_valid=0 on the next edge, no ready pulses, and the first tie after release goes to m0.
